// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// controller opcodes, the LSU state type and the lane/classification helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Opcodes that steer the controller into MEMORY_READ / MEMORY_WRITE
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // Byte enables for the access width, shifted into the addressed lane
   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Store data replicated so the addressed lane always carries the value
   function automatic logic [31:0] store_steer(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] s;
      case (f3[1:0])
         2'b00:   s = {4{wd[7:0]}};
         2'b01:   s = {2{wd[15:0]}};
         default: s = wd;
      endcase
      return s;
   endfunction

   // Requests that finish with err and never reach the bus. funct3=011 has
   // no RV32I load or store meaning, so it is rejected for both directions.
   function automatic logic req_bad(input logic wr, input logic [2:0] f3, input logic [1:0] off);
      logic illegal;
      logic misaligned;
      illegal    = (f3[2:1] == 2'b11) || (f3 == 3'b011) ||
                   (wr && !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W)));
      misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                   ((f3[1:0] == 2'b10) && (off != 2'b00));
      return illegal || misaligned;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Load-data extraction: selects the addressed byte/half of the raw bus word
// and sign- or zero-extends it according to funct3.
module load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);

   logic [31:0] shifted;

   assign shifted = word >> {off, 3'b000};

   // Width/sign selection on the lane-aligned word
   always_comb begin
      ext = word;
      case (funct3)
         F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ext = {24'h0, shifted[7:0]};
         F3_HU:   ext = {16'h0, shifted[15:0]};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: classifies one request, runs a req/ack access to
// data memory with a timeout, and returns extended load data with a
// one-cycle done pulse. All bus outputs are registered.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   lsu_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        off_q, off_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [31:0]       load_ext;

   // Captured funct3/offset drive extension while the bus is busy
   load_extend u_load_extend (
      .word   (mem_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .ext    (load_ext)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Next-state and output computation for the IDLE/REQ/DONE sequence
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      f3_d        = f3_q;
      off_d       = off_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_valid) begin
               if (req_bad(req_write, funct3, addr[1:0])) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else begin
                  state_d     = REQ;
                  f3_d        = funct3;
                  off_d       = addr[1:0];
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_write;
                  mem_be_d    = lane_be(funct3, addr[1:0]);
                  mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  mem_wdata_d = store_steer(funct3, wdata);
               end
            end
         end
         REQ: begin
            // Ack takes priority over the timeout on the same cycle
            if (mem_ack) begin
               state_d   = DONE;
               done_d    = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               cnt_d     = '0;
               if (!mem_we_q) begin
                  rdata_d = load_ext;
               end
            end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
               state_d   = DONE;
               done_d    = 1'b1;
               err_d     = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and registered outputs; reset clears the bus request immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         f3_q        <= '0;
         off_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         f3_q        <= f3_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign rdata     = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios followed by randomized
// transactions, each compared against an arithmetic model of the access rules.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_rd   = 32'h0;

   load_store_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_write (req_write),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_be    (mem_be),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---- reference model: access rules in plain arithmetic ----
   function automatic bit m_bad(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      int sz = int'(f3[1:0]);
      if (f3 >= 3'd6) return 1'b1;
      if (f3 == 3'd3) return 1'b1;
      if (wr && f3 > 3'd2) return 1'b1;
      if (sz == 1 && (a % 2) != 0) return 1'b1;
      if (sz == 2 && (a % 4) != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      int n = 1 << int'(f3[1:0]);
      int v = ((1 << n) - 1) << int'(a % 4);
      return v[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int n = 1 << int'(f3[1:0]);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
      int n = 1 << int'(f3[1:0]);
      logic [63:0] v;
      logic [63:0] mask;
      v = {32'h0, w} >> (8 * int'(a % 4));
      if (n < 4) begin
         mask = (64'd1 << (8 * n)) - 64'd1;
         v = v & mask;
         if (!f3[2] && v[8*n-1]) v = v | ~mask;
      end
      return v[31:0];
   endfunction

   // Random values on request inputs while busy; the DUT must ignore them
   task automatic scramble();
      req_valid = 1'($urandom % 2);
      req_write = 1'($urandom % 2);
      funct3    = 3'($urandom % 8);
      addr      = $urandom;
      wdata     = $urandom;
   endtask

   // One request. ackd = REQ cycle (0-based) carrying mem_ack, or -1 for none.
   task automatic do_txn(input string tag, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] mrd, input int ackd);
      bit bad;
      bit acked;
      int c;
      bad   = m_bad(wr, f3, a);
      acked = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
      @(posedge clk);
      if (bad) begin
         @(negedge clk);
         scramble();
         mem_ack = 1'($urandom % 2);
         chk({tag, ".err_done"}, done, 1);
         chk({tag, ".err_err"}, err, 1);
         chk({tag, ".err_noreq"}, mem_req, 0);
         chk({tag, ".err_busy"}, busy, 1);
         chk({tag, ".err_rdata"}, rdata, exp_rd);
      end else begin
         c = 0;
         while (!acked && c < TO) begin
            @(negedge clk);
            scramble();
            chk({tag, ".req"}, mem_req, 1);
            chk({tag, ".we"}, mem_we, wr);
            chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
            chk({tag, ".be"}, mem_be, m_be(f3, a));
            if (wr) chk({tag, ".wdata"}, mem_wdata, m_wdata(f3, wd));
            chk({tag, ".nodone"}, done, 0);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".hold"}, rdata, exp_rd);
            acked     = (c == ackd);
            mem_ack   = acked;
            mem_rdata = acked ? mrd : $urandom;
            c++;
         end
         if (acked && !wr) exp_rd = m_rdata(f3, a, mrd);
         @(negedge clk);
         scramble();
         mem_ack   = 1'($urandom % 2);
         mem_rdata = $urandom;
         chk({tag, ".done"}, done, 1);
         chk({tag, ".err"}, err, !acked);
         chk({tag, ".reqdrop"}, mem_req, 0);
         chk({tag, ".busy_d"}, busy, 1);
         chk({tag, ".rdata"}, rdata, exp_rd);
      end
      @(negedge clk);
      chk({tag, ".idle_done"}, done, 0);
      chk({tag, ".idle_busy"}, busy, 0);
      chk({tag, ".idle_req"}, mem_req, 0);
      chk({tag, ".idle_rdata"}, rdata, exp_rd);
      req_valid = 1'b0;
      mem_ack   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit wr;
      logic [2:0] f3;
      logic [31:0] a;
      int ad;

      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; funct3 = 3'b0;
      addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      #1;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.err", err, 0);
      chk("rst.req", mem_req, 0);
      chk("rst.we", mem_we, 0);
      chk("rst.be", mem_be, 0);
      chk("rst.addr", mem_addr, 0);
      chk("rst.wdata", mem_wdata, 0);
      chk("rst.rdata", rdata, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      do_txn("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
      chk("lw.const", rdata, 32'hDEADBEEF);
      do_txn("lb",  1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
      chk("lb.const", rdata, 32'hFFFFFF80);
      do_txn("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0);
      chk("lbu.const", rdata, 32'h00000080);
      do_txn("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 0);
      chk("lhu.const", rdata, 32'h000080FF);
      do_txn("sb",  1'b1, 3'b000, 32'h21, 32'h000000AB, 32'h0, 0);
      do_txn("sw_mis", 1'b1, 3'b010, 32'h22, 32'h12345678, 32'h0, 0);
      do_txn("f3_011", 1'b1, 3'b011, 32'h20, 32'h12345678, 32'h0, 0);
      do_txn("lw_to",  1'b0, 3'b010, 32'h200, 32'h0, 32'h11111111, -1);
      chk("lw_to.const", rdata, 32'h000080FF);
      do_txn("lw_ack4", 1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, TO - 1);
      chk("lw_ack4.const", rdata, 32'hCAFEF00D);

      // Asynchronous reset in the middle of a bus access
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h40;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid.req_before", mem_req, 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("mid.req", mem_req, 0);
      chk("mid.busy", busy, 0);
      chk("mid.done", done, 0);
      chk("mid.rdata", rdata, 0);
      exp_rd = 32'h0;
      @(negedge clk);
      reset = 1'b1;
      do_txn("lh0", 1'b0, 3'b001, 32'h0, 32'h0, 32'h00007FFF, 1);
      chk("lh0.const", rdata, 32'h00007FFF);

      // Randomized requests across widths, offsets, directions and ack delays
      for (int i = 0; i < 150; i++) begin
         wr = 1'($urandom % 2);
         if (wr) f3 = 3'($urandom % 8);
         else begin
            f3 = 3'($urandom % 7);
            if (f3 >= 3'd3) f3 = f3 + 3'd1;
         end
         a  = $urandom;
         if (($urandom % 3) == 0) a[1:0] = 2'b00;
         ad = int'($urandom_range(0, 5));
         if (ad >= TO) ad = -1;
         do_txn("rnd", wr, f3, a, $urandom, $urandom, ad);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
